fft_agu_sequencer: RTL
======================

Name: fft_agu_sequencer

Overview:
- Initiator that drives the butterfly address generator.
- On start, walks every stage (0..log2N-1) and every butterfly pair (0..N/2-1), issuing one stage/pair_id per accepted cycle.
- Carries a valid/tag pipeline matched to the generator's fixed 2-cycle latency, so the datapath knows when address1/address2 are valid and which stage/pair they belong to.
- Inserts a drain gap between stages and reports busy/done to the top-level FFT controller.

Parameters:
- N, 8, FFT size; power of two, >= 4. log2N = $clog2(N).
- AGU_LAT, 2, cycles from stage/pair_id presented to matching addresses registered at the generator output.
- STAGE_GAP, 1, extra idle cycles after a stage's pipeline drains, before the next stage issues (RAM write-back margin); >= 0.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to run a full FFT; ignored while busy.
- abort  in  1  synchronous flush: return to IDLE next edge; pending tags discarded.
- ready  in  1  butterfly datapath accepts an issue this cycle.
- stage  out  log2N  stage index to the generator.
- pair_id  out  log2N-1  pair index to the generator.
- issue  out  1  stage/pair_id accepted this cycle (ISSUE state && ready).
- tw_index  out  log2N-1  twiddle index for the issued pair.
- tag_valid  out  1  generator addresses are valid this cycle.
- tag_stage  out  log2N  stage belonging to the valid addresses.
- tag_last  out  1  valid addresses are the final pair of the final stage.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse when the FFT completes.

Behaviour:
- Reset (async): state=IDLE; stage, pair_id, tw_index, tag_stage = 0; issue, tag_valid, tag_last, busy, done = 0; drain counter = 0.

States:
- IDLE
  - stage=0, pair_id=0.
  - start=1 -> ISSUE with stage=0, pair_id=0.
- ISSUE
  - issue = ready.
  - On issue with pair_id < N/2-1: pair_id++.
  - On issue with pair_id == N/2-1: -> DRAIN, counter loaded with AGU_LAT+STAGE_GAP-1.
  - ready=0: stage and pair_id hold, no issue.
- DRAIN
  - Lasts exactly AGU_LAT+STAGE_GAP cycles, counting down to 0.
  - At 0: if stage == log2N-1 -> DONE; else stage++, pair_id=0, -> ISSUE.
- DONE
  - done=1 for one cycle, busy still 1, then -> IDLE.

Tag pipeline and arithmetic:
- Depth AGU_LAT shift register of {issue, stage, last}, advancing every cycle regardless of ready.
- tag_valid/tag_stage/tag_last = pipeline output.
- last = issue && stage==log2N-1 && pair_id==N/2-1.
- tw_index = pair_id with its low (log2N-1-stage) bits cleared (mask computed in log2N-1 bits). Registered only on issue; holds otherwise.
- pair_id wraps only via the DRAIN->ISSUE reload, never by overflow.

Boundary cases:
- start while busy: ignored.
- start and abort in the same cycle: abort wins, state=IDLE.
- abort in any state: next edge state=IDLE and the entire tag pipeline cleared, so no stale tag_valid. done is not asserted.
- reset mid-operation: immediate return to reset values.
- ready toggling: the issue count per stage is always exactly N/2; stalls only stretch ISSUE.

Test Plan:
- Timing convention: edge 0 is the edge that samples start; period k is the period after edge k.
- N=8, AGU_LAT=2, STAGE_GAP=1, ready=1, start pulse -> ISSUE periods 1-4, 8-11, 15-18 with pair_id 0,1,2,3 each; DRAIN 5-7, 12-14, 19-21; done=1 only in period 22; busy periods 1-22; tag_valid in periods 3-6, 10-13, 17-20; tag_last only in period 20.
- Same run, tw_index at issue -> stage0: 0,0,0,0; stage1: 0,0,2,2; stage2: 0,1,2,3.
- ready held low for periods 2-3 of stage 0 -> pair_id holds at 1, exactly 4 issues in stage 0, tag_valid has a matching 2-cycle hole, done shifts to period 24.
- Integration with the generator, N=8: tag_valid with tag_stage=1 for pair 1 -> address1=4, address2=6; stage 0, pair 3 -> 6, 7.
- abort in period 9 -> IDLE in period 10; tag_valid 0 from period 10; done never pulses; a new start then runs a clean 22-cycle sequence.
- start pulsed during period 12 -> ignored, sequence unchanged; reset asserted mid-DRAIN -> all outputs 0 immediately.

Source files
------------

// File: rtl/fft_agu_sequencer.sv
// ---------------------------------------------------------------------------
// fft_agu_sequencer
//   Drives the butterfly address generator. On start it walks every stage
//   (0..log2N-1) and, within each stage, every butterfly pair (0..N/2-1),
//   presenting one stage/pair_id per accepted cycle. A tag pipeline matched
//   to the generator latency tells the datapath when the generator's
//   addresses are valid, and which stage they belong to. Between stages the
//   sequencer waits for the pipeline to drain, plus an optional gap.
//
// Ports
//   i_clk        system clock, rising edge
//   i_reset      asynchronous, active-high reset
//   i_start      one-cycle run request; ignored while busy
//   i_abort      synchronous flush back to IDLE; pending tags dropped
//   i_ready      datapath accepts an issue this cycle
//   o_stage      stage index to the generator
//   o_pair_id    pair index to the generator
//   o_issue      stage/pair_id accepted this cycle
//   o_tw_index   twiddle index of the most recently issued pair
//   o_tag_valid  generator addresses valid this cycle
//   o_tag_stage  stage of the valid addresses (0 when not valid)
//   o_tag_last   valid addresses are the final pair of the final stage
//   o_busy       high in every state except IDLE
//   o_done       one-cycle completion pulse
// ---------------------------------------------------------------------------
module fft_agu_sequencer #(
  parameter  int N         = 8,
  parameter  int AGU_LAT   = 2,
  parameter  int STAGE_GAP = 1,
  localparam int LOG2N     = $clog2(N),
  localparam int PW        = LOG2N - 1
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic             i_ready,
  output logic [LOG2N-1:0] o_stage,
  output logic [PW-1:0]    o_pair_id,
  output logic             o_issue,
  output logic [PW-1:0]    o_tw_index,
  output logic             o_tag_valid,
  output logic [LOG2N-1:0] o_tag_stage,
  output logic             o_tag_last,
  output logic             o_busy,
  output logic             o_done
);

  localparam int DRAIN_CYC = AGU_LAT + STAGE_GAP;
  localparam int CW        = $clog2(DRAIN_CYC + 1);

  localparam logic [PW-1:0]    LAST_PAIR  = PW'(N/2 - 1);
  localparam logic [LOG2N-1:0] LAST_STAGE = LOG2N'(LOG2N - 1);
  localparam logic [CW-1:0]    DRAIN_INIT = CW'(DRAIN_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [LOG2N-1:0]     r_stage, w_stage_nxt;
  logic [PW-1:0]        r_pair,  w_pair_nxt;
  logic [CW-1:0]        r_cnt,   w_cnt_nxt;
  logic [PW-1:0]        r_tw;

  logic [AGU_LAT-1:0]            r_tag_v;
  logic [AGU_LAT-1:0][LOG2N-1:0] r_tag_stage;
  logic [AGU_LAT-1:0]            r_tag_last;

  logic                 w_issue;
  logic                 w_last_pair;
  logic                 w_last_stage;
  logic                 w_last;
  logic [LOG2N-1:0]     w_shamt;
  logic [PW-1:0]        w_mask;

  assign w_issue      = (r_state == S_ISSUE) && i_ready;
  assign w_last_pair  = (r_pair == LAST_PAIR);
  assign w_last_stage = (r_stage == LAST_STAGE);
  assign w_last       = w_issue && w_last_pair && w_last_stage;

  // Twiddle index: clear the low (log2N-1-stage) bits of pair_id. Stage 0
  // clears every bit (shift by PW yields an all-zero mask).
  assign w_shamt = LAST_STAGE - r_stage;
  assign w_mask  = {PW{1'b1}} << w_shamt;

  // -------------------------------------------------------------------------
  // FSM state register
  // -------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_stage <= '0;
      r_pair  <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_stage <= w_stage_nxt;
      r_pair  <= w_pair_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // -------------------------------------------------------------------------
  // FSM next-state
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_stage_nxt = r_stage;
    w_pair_nxt  = r_pair;
    w_cnt_nxt   = r_cnt;
    if (i_abort) begin
      // abort beats start and every in-flight state
      w_state_nxt = S_IDLE;
      w_stage_nxt = '0;
      w_pair_nxt  = '0;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_stage_nxt = '0;
          w_pair_nxt  = '0;
          if (i_start) w_state_nxt = S_ISSUE;
        end
        S_ISSUE: begin
          if (w_issue) begin
            if (w_last_pair) begin
              // pair_id parks at N/2-1; it is only reloaded on the next stage
              w_state_nxt = S_DRAIN;
              w_cnt_nxt   = DRAIN_INIT;
            end else begin
              w_pair_nxt = r_pair + 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (r_cnt == '0) begin
            if (w_last_stage) begin
              w_state_nxt = S_DONE;
            end else begin
              w_state_nxt = S_ISSUE;
              w_stage_nxt = r_stage + 1'b1;
              w_pair_nxt  = '0;
            end
          end else begin
            w_cnt_nxt = r_cnt - 1'b1;
          end
        end
        S_DONE: begin
          w_state_nxt = S_IDLE;
          w_stage_nxt = '0;
          w_pair_nxt  = '0;
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_stage_nxt = '0;
          w_pair_nxt  = '0;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Twiddle index: captured only on an accepted issue
  // -------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)      r_tw <= '0;
    else if (w_issue) r_tw <= r_pair & w_mask;
  end

  // -------------------------------------------------------------------------
  // Tag pipeline: AGU_LAT deep, advances every cycle independent of ready so
  // its output lines up with the generator's registered addresses. Stage is
  // zeroed on non-issue slots so tag_stage reads 0 whenever tag_valid is low.
  // -------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_tag_v     <= '0;
      r_tag_stage <= '0;
      r_tag_last  <= '0;
    end else if (i_abort) begin
      r_tag_v     <= '0;
      r_tag_stage <= '0;
      r_tag_last  <= '0;
    end else begin
      for (int i = AGU_LAT - 1; i > 0; i--) begin
        r_tag_v[i]     <= r_tag_v[i-1];
        r_tag_stage[i] <= r_tag_stage[i-1];
        r_tag_last[i]  <= r_tag_last[i-1];
      end
      r_tag_v[0]     <= w_issue;
      r_tag_stage[0] <= w_issue ? r_stage : '0;
      r_tag_last[0]  <= w_last;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign o_stage     = r_stage;
  assign o_pair_id   = r_pair;
  assign o_issue     = w_issue;
  assign o_tw_index  = r_tw;
  assign o_tag_valid = r_tag_v[AGU_LAT-1];
  assign o_tag_stage = r_tag_stage[AGU_LAT-1];
  assign o_tag_last  = r_tag_last[AGU_LAT-1];
  assign o_busy      = (r_state != S_IDLE);
  assign o_done      = (r_state == S_DONE);

endmodule
